// File: rtl/dcmac_rx_pkg.sv
// Shared definitions for the DCMAC RX segmented stream path.
package dcmac_rx_pkg;

    localparam int SEG_W     = 128;
    localparam int TID_W     = 4;
    localparam int TUSER_W   = 3;

    // Per-segment tuser bit positions: {ENA,SOP,ERR}
    localparam int TUSER_ERR = 0;
    localparam int TUSER_SOP = 1;
    localparam int TUSER_ENA = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/axis_seg_reg_slice.sv
// Output register for the merged segmented stream. A beat is loaded whenever
// the slot is empty or being drained; when nothing is offered on a load the
// slot goes empty and the payload is simply left as it was.
module axis_seg_reg_slice
    import dcmac_rx_pkg::*;
#(
    parameter int SEG_COUNT = 2
)
(
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         load,
    input  logic                         in_valid,
    input  logic                         in_port,
    input  logic [SEG_COUNT*SEG_W-1:0]   in_tdata,
    input  logic [SEG_COUNT*TID_W-1:0]   in_tid,
    input  logic [SEG_COUNT*TUSER_W-1:0] in_tuser,
    input  logic [SEG_COUNT-1:0]         in_tlast,
    output logic [SEG_COUNT*SEG_W-1:0]   out_tdata,
    output logic [SEG_COUNT*TID_W-1:0]   out_tid,
    output logic [SEG_COUNT*TUSER_W-1:0] out_tuser,
    output logic [SEG_COUNT-1:0]         out_tlast,
    output logic                         out_tport,
    output logic                         out_tvalid
);

    // Load a new beat (or an empty slot) whenever the downstream can take it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_tvalid <= 1'b0;
            out_tport  <= 1'b0;
            out_tdata  <= '0;
            out_tid    <= '0;
            out_tuser  <= '0;
            out_tlast  <= '0;
        end else if (load) begin
            out_tvalid <= in_valid;
            out_tport  <= in_port;
            if (in_valid) begin
                out_tdata <= in_tdata;
                out_tid   <= in_tid;
                out_tuser <= in_tuser;
                out_tlast <= in_tlast;
            end
        end
    end

endmodule

// File: rtl/dcmac_rx_port_arbiter.sv
// Packet-granular round-robin merge of two RX logical-port streams.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no grant held; arbitrate combinationally on the current tvalids
// BUSY  | owner holds the grant until its EOP beat is accepted
module dcmac_rx_port_arbiter
    import dcmac_rx_pkg::*;
#(
    parameter int SEG_COUNT = 2,
    parameter int CNT_W     = 32
)
(
    input  logic                         clk,
    input  logic                         resetn,

    input  logic [SEG_COUNT*SEG_W-1:0]   in0_tdata,
    input  logic [SEG_COUNT*TID_W-1:0]   in0_tid,
    input  logic [SEG_COUNT*TUSER_W-1:0] in0_tuser,
    input  logic [SEG_COUNT-1:0]         in0_tlast,
    input  logic                         in0_tvalid,
    output logic                         in0_tready,

    input  logic [SEG_COUNT*SEG_W-1:0]   in1_tdata,
    input  logic [SEG_COUNT*TID_W-1:0]   in1_tid,
    input  logic [SEG_COUNT*TUSER_W-1:0] in1_tuser,
    input  logic [SEG_COUNT-1:0]         in1_tlast,
    input  logic                         in1_tvalid,
    output logic                         in1_tready,

    output logic [SEG_COUNT*SEG_W-1:0]   out_tdata,
    output logic [SEG_COUNT*TID_W-1:0]   out_tid,
    output logic [SEG_COUNT*TUSER_W-1:0] out_tuser,
    output logic [SEG_COUNT-1:0]         out_tlast,
    output logic                         out_tport,
    output logic                         out_tvalid,
    input  logic                         out_tready,

    output logic [CNT_W-1:0]             pkt_count0,
    output logic [CNT_W-1:0]             pkt_count1,
    output logic                         sop_err
);

    arb_state_t state_q, state_d;
    logic owner_q, owner_d;
    logic rr_last_q;
    logic first_q;

    logic load;
    logic arb_port;
    logic cur_owner;
    logic sel_valid;
    logic acc;
    logic eop;
    logic other_valid;

    logic [SEG_COUNT*SEG_W-1:0]   sel_tdata;
    logic [SEG_COUNT*TID_W-1:0]   sel_tid;
    logic [SEG_COUNT*TUSER_W-1:0] sel_tuser;
    logic [SEG_COUNT-1:0]         sel_tlast;

    assign load = !out_tvalid || out_tready;

    // Round-robin pick among the ports presenting a beat right now
    always_comb begin
        arb_port = 1'b0;
        if (in0_tvalid && in1_tvalid) begin
            arb_port = ~rr_last_q;
        end else if (in1_tvalid) begin
            arb_port = 1'b1;
        end
    end

    // In IDLE the pick drives tready directly, so a new packet never waits a cycle
    assign cur_owner = (state_q == IDLE) ? arb_port : owner_q;

    assign sel_tdata = cur_owner ? in1_tdata  : in0_tdata;
    assign sel_tid   = cur_owner ? in1_tid    : in0_tid;
    assign sel_tuser = cur_owner ? in1_tuser  : in0_tuser;
    assign sel_tlast = cur_owner ? in1_tlast  : in0_tlast;
    assign sel_valid = cur_owner ? in1_tvalid : in0_tvalid;

    assign in0_tready = load && !cur_owner;
    assign in1_tready = load &&  cur_owner;

    assign acc         = load && sel_valid;
    assign eop         = |sel_tlast;
    assign other_valid = owner_q ? in0_tvalid : in1_tvalid;

    // Next-state: hold the grant for a whole packet, re-arbitrate on its EOP
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                // a single-beat packet completes here and arbitration repeats next cycle
                if (acc && !eop) begin
                    state_d = BUSY;
                    owner_d = cur_owner;
                end
            end
            BUSY: begin
                if (acc && eop) begin
                    // The owner's tvalid at its EOP says nothing about a following
                    // packet, so only a waiting peer is granted directly; otherwise
                    // IDLE re-arbitrates next cycle on fresh tvalids, with no bubble.
                    if (other_valid) begin
                        owner_d = ~owner_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Packet bookkeeping on accepted beats: fairness pointer, counters, SOP check
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_last_q  <= 1'b1;
            first_q    <= 1'b1;
            pkt_count0 <= '0;
            pkt_count1 <= '0;
            sop_err    <= 1'b0;
        end else if (acc) begin
            first_q <= eop;
            if (first_q && !sel_tuser[TUSER_SOP]) begin
                sop_err <= 1'b1;
            end
            if (eop) begin
                rr_last_q <= cur_owner;
                if (cur_owner) begin
                    pkt_count1 <= pkt_count1 + CNT_W'(1);
                end else begin
                    pkt_count0 <= pkt_count0 + CNT_W'(1);
                end
            end
        end
    end

    axis_seg_reg_slice #(
        .SEG_COUNT (SEG_COUNT)
    ) u_out_slice (
        .clk        (clk),
        .resetn     (resetn),
        .load       (load),
        .in_valid   (acc),
        .in_port    (cur_owner),
        .in_tdata   (sel_tdata),
        .in_tid     (sel_tid),
        .in_tuser   (sel_tuser),
        .in_tlast   (sel_tlast),
        .out_tdata  (out_tdata),
        .out_tid    (out_tid),
        .out_tuser  (out_tuser),
        .out_tlast  (out_tlast),
        .out_tport  (out_tport),
        .out_tvalid (out_tvalid)
    );

endmodule

// File: tb/tb_dcmac_rx_port_arbiter.sv
// Directed bench for the two-port RX packet arbiter.
module tb_dcmac_rx_port_arbiter;
    import dcmac_rx_pkg::*;

    localparam int SEG_COUNT = 2;
    localparam int CNT_W     = 32;
    localparam int DW        = SEG_COUNT * SEG_W;
    localparam int IW        = SEG_COUNT * TID_W;
    localparam int UW        = SEG_COUNT * TUSER_W;

    typedef struct {
        logic [DW-1:0]        data;
        logic [IW-1:0]        tid;
        logic [UW-1:0]        tuser;
        logic [SEG_COUNT-1:0] tlast;
    } beat_t;

    typedef struct {
        beat_t b;
        logic  port;
        int    cyc;
    } obs_t;

    logic clk = 1'b0;
    logic resetn;
    logic [DW-1:0] in0_tdata, in1_tdata, out_tdata;
    logic [IW-1:0] in0_tid, in1_tid, out_tid;
    logic [UW-1:0] in0_tuser, in1_tuser, out_tuser;
    logic [SEG_COUNT-1:0] in0_tlast, in1_tlast, out_tlast;
    logic in0_tvalid, in1_tvalid, in0_tready, in1_tready;
    logic out_tport, out_tvalid, out_tready;
    logic [CNT_W-1:0] pkt_count0, pkt_count1;
    logic sop_err;

    beat_t q0[$];
    beat_t q1[$];
    obs_t  oq[$];
    obs_t  eq[$];
    int    aq[$];
    int    cyc;
    int    checks;
    int    errors;
    logic  toggle_rdy;

    always #5 clk = ~clk;

    dcmac_rx_port_arbiter #(.SEG_COUNT(SEG_COUNT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in0_tdata  (in0_tdata),
        .in0_tid    (in0_tid),
        .in0_tuser  (in0_tuser),
        .in0_tlast  (in0_tlast),
        .in0_tvalid (in0_tvalid),
        .in0_tready (in0_tready),
        .in1_tdata  (in1_tdata),
        .in1_tid    (in1_tid),
        .in1_tuser  (in1_tuser),
        .in1_tlast  (in1_tlast),
        .in1_tvalid (in1_tvalid),
        .in1_tready (in1_tready),
        .out_tdata  (out_tdata),
        .out_tid    (out_tid),
        .out_tuser  (out_tuser),
        .out_tlast  (out_tlast),
        .out_tport  (out_tport),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .pkt_count0 (pkt_count0),
        .pkt_count1 (pkt_count1),
        .sop_err    (sop_err)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t gen_beat(input logic port, input int pkt, input int n, input int i,
                                       input logic sop_ok);
        beat_t b;
        b.data = '0;
        b.data[31:0]       = {8'(port), 8'(pkt), 8'(i), 8'hC3};
        b.data[SEG_W +: 32] = {8'hD0, 8'(pkt), 8'(i), 8'(port)};
        b.tid   = {4'(i), 4'(pkt)};
        b.tuser = {3'b100, 1'b1, (i == 0) && sop_ok, 1'b0};
        if (i != n - 1)  b.tlast = 2'b00;
        else if (n == 1) b.tlast = 2'b01;
        else             b.tlast = 2'b10;
        return b;
    endfunction

    task automatic src_pkt(input logic port, input int pkt, input int n, input logic sop_ok);
        for (int i = 0; i < n; i++) begin
            if (port) q1.push_back(gen_beat(port, pkt, n, i, sop_ok));
            else      q0.push_back(gen_beat(port, pkt, n, i, sop_ok));
        end
    endtask

    task automatic exp_pkt(input logic port, input int pkt, input int n, input logic sop_ok);
        obs_t o;
        for (int i = 0; i < n; i++) begin
            o.b    = gen_beat(port, pkt, n, i, sop_ok);
            o.port = port;
            o.cyc  = 0;
            eq.push_back(o);
        end
    endtask

    task automatic drive();
        in0_tvalid = (q0.size() > 0);
        if (q0.size() > 0) begin
            in0_tdata = q0[0].data; in0_tid = q0[0].tid;
            in0_tuser = q0[0].tuser; in0_tlast = q0[0].tlast;
        end
        in1_tvalid = (q1.size() > 0);
        if (q1.size() > 0) begin
            in1_tdata = q1[0].data; in1_tid = q1[0].tid;
            in1_tuser = q1[0].tuser; in1_tlast = q1[0].tlast;
        end
        out_tready = toggle_rdy ? ~out_tready : 1'b1;
    endtask

    task automatic step();
        logic a0, a1;
        obs_t o;
        @(negedge clk);
        a0 = in0_tvalid & in0_tready;
        a1 = in1_tvalid & in1_tready;
        if (a0 || a1) aq.push_back(cyc);
        if (out_tvalid && out_tready) begin
            o.b.data = out_tdata; o.b.tid = out_tid;
            o.b.tuser = out_tuser; o.b.tlast = out_tlast;
            o.port = out_tport; o.cyc = cyc;
            oq.push_back(o);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (a0) void'(q0.pop_front());
        if (a1) void'(q1.pop_front());
        drive();
    endtask

    task automatic run(input string tag, input int maxc);
        int n;
        n = 0;
        drive();
        while ((q0.size() > 0 || q1.size() > 0 || out_tvalid) && n < maxc) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, DW'(n >= maxc), DW'(0));
    endtask

    task automatic check_stream(input string tag);
        int m;
        chk({tag, "_nbeats"}, DW'(oq.size()), DW'(eq.size()));
        m = (oq.size() < eq.size()) ? oq.size() : eq.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s_port%0d", tag, i), DW'(oq[i].port), DW'(eq[i].port));
            chk($sformatf("%s_data%0d", tag, i), oq[i].b.data, eq[i].b.data);
            chk($sformatf("%s_side%0d", tag, i),
                DW'({oq[i].b.tid, oq[i].b.tuser, oq[i].b.tlast}),
                DW'({eq[i].b.tid, eq[i].b.tuser, eq[i].b.tlast}));
        end
        oq.delete(); eq.delete(); aq.delete();
    endtask

    task automatic release_reset();
        q0.delete(); q1.delete();
        drive();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        oq.delete(); eq.delete(); aq.delete();
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; toggle_rdy = 1'b0;
        resetn = 1'b0; out_tready = 1'b1;
        in0_tvalid = 1'b0; in1_tvalid = 1'b0;
        in0_tdata = '0; in0_tid = '0; in0_tuser = '0; in0_tlast = '0;
        in1_tdata = '0; in1_tid = '0; in1_tuser = '0; in1_tlast = '0;
        #12;
        chk("rst_tvalid", DW'(out_tvalid), DW'(0));
        chk("rst_tdata", out_tdata, DW'(0));
        chk("rst_tport", DW'(out_tport), DW'(0));
        chk("rst_cnt0", DW'(pkt_count0), DW'(0));
        chk("rst_cnt1", DW'(pkt_count1), DW'(0));
        chk("rst_sop_err", DW'(sop_err), DW'(0));
        release_reset();

        // Port 0 only: 3 packets x 4 beats, contiguous, 1-cycle latency
        for (int p = 0; p < 3; p++) begin
            src_pkt(1'b0, p, 4, 1'b1);
            exp_pkt(1'b0, p, 4, 1'b1);
        end
        run("p0only", 100);
        chk("p0only_latency", DW'(oq[0].cyc - aq[0]), DW'(1));
        chk("p0only_contig", DW'(oq[11].cyc - oq[0].cyc), DW'(11));
        chk("p0only_cnt0", DW'(pkt_count0), DW'(3));
        check_stream("p0only");

        // Both ports, 2-beat packets: 0,0,1,1,... with no gap
        resetn = 1'b0;
        #1;
        release_reset();
        for (int p = 0; p < 3; p++) begin
            src_pkt(1'b0, p, 2, 1'b1);
            src_pkt(1'b1, p, 2, 1'b1);
            exp_pkt(1'b0, p, 2, 1'b1);
            exp_pkt(1'b1, p, 2, 1'b1);
        end
        run("rr2", 100);
        chk("rr2_contig", DW'(oq[11].cyc - oq[0].cyc), DW'(11));
        chk("rr2_cnt0", DW'(pkt_count0), DW'(3));
        chk("rr2_cnt1", DW'(pkt_count1), DW'(3));
        check_stream("rr2");

        // Single-beat packets on both ports: grant alternates every cycle
        for (int p = 0; p < 3; p++) begin
            src_pkt(1'b0, 10 + p, 1, 1'b1);
            src_pkt(1'b1, 10 + p, 1, 1'b1);
            exp_pkt(1'b0, 10 + p, 1, 1'b1);
            exp_pkt(1'b1, 10 + p, 1, 1'b1);
        end
        run("single", 100);
        chk("single_contig", DW'(oq[5].cyc - oq[0].cyc), DW'(5));
        chk("single_cnt0", DW'(pkt_count0), DW'(6));
        chk("single_cnt1", DW'(pkt_count1), DW'(6));
        check_stream("single");

        // Back-pressure toggling during a 5-beat port 0 packet, port 1 waiting
        src_pkt(1'b0, 20, 5, 1'b1);
        src_pkt(1'b1, 20, 2, 1'b1);
        exp_pkt(1'b0, 20, 5, 1'b1);
        exp_pkt(1'b1, 20, 2, 1'b1);
        toggle_rdy = 1'b1;
        run("bp", 100);
        toggle_rdy = 1'b0;
        chk("bp_cnt0", DW'(pkt_count0), DW'(7));
        chk("bp_cnt1", DW'(pkt_count1), DW'(7));
        check_stream("bp");

        // Missing SOP on a granted packet's first beat: forwarded, flag sticks
        chk("sop_err_clear", DW'(sop_err), DW'(0));
        src_pkt(1'b0, 30, 2, 1'b0);
        src_pkt(1'b0, 31, 2, 1'b1);
        exp_pkt(1'b0, 30, 2, 1'b0);
        exp_pkt(1'b0, 31, 2, 1'b1);
        run("sop", 100);
        chk("sop_err_set", DW'(sop_err), DW'(1));
        check_stream("sop");
        src_pkt(1'b1, 32, 3, 1'b1);
        exp_pkt(1'b1, 32, 3, 1'b1);
        run("sop_later", 100);
        chk("sop_err_sticky", DW'(sop_err), DW'(1));
        chk("sop_cnt0", DW'(pkt_count0), DW'(9));
        chk("sop_cnt1", DW'(pkt_count1), DW'(8));
        check_stream("sop_later");

        // Async reset in the middle of a packet
        src_pkt(1'b0, 40, 4, 1'b1);
        drive();
        step();
        step();
        chk("mid_tvalid_before", DW'(out_tvalid), DW'(1));
        #3;
        resetn = 1'b0;
        #1;
        chk("mid_rst_tvalid", DW'(out_tvalid), DW'(0));
        chk("mid_rst_tdata", out_tdata, DW'(0));
        chk("mid_rst_cnt0", DW'(pkt_count0), DW'(0));
        chk("mid_rst_sop_err", DW'(sop_err), DW'(0));
        release_reset();
        src_pkt(1'b1, 50, 1, 1'b1);
        src_pkt(1'b0, 50, 1, 1'b1);
        exp_pkt(1'b0, 50, 1, 1'b1);
        exp_pkt(1'b1, 50, 1, 1'b1);
        run("post_rst", 100);
        chk("post_rst_cnt0", DW'(pkt_count0), DW'(1));
        chk("post_rst_cnt1", DW'(pkt_count1), DW'(1));
        check_stream("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
